// File: rtl/alu_pkg.sv
// Shared types for the iterative execute-stage ALU: op codes, FSM states and
// the shift-amount width helper.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int SHAMT_W    = $clog2(ALU_DATA_W);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SLT = 4'b1100,
    OP_SLL = 4'b1101
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: logic, add/sub, signed compare and equality.
// Shift codes and undefined codes produce zero here; the top handles shifts.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_BEQ:  y = {{(DATA_W-1){1'b0}}, (a == b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU with valid/ready on both sides. One-cycle ops finish at the
// accept edge; shifts iterate SHIFT_STEP positions per cycle in the SHIFT state.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int DATA_W     = ALU_DATA_W,
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero
);

  localparam int SH_W  = (DATA_W == ALU_DATA_W) ? SHAMT_W : $clog2(DATA_W);
  // One extra bit so a step of DATA_W positions is representable.
  localparam int CNT_W = SH_W + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

  alu_state_e        state, state_n;
  logic [DATA_W-1:0] acc, acc_n, acc_sh, res_n, core_y;
  logic [CNT_W-1:0]  rem, rem_n, k;
  logic [3:0]        op_q, op_n;
  logic [SH_W-1:0]   shamt;
  logic              vld_n, accept, step_last, stall;

  alu_comb_core #(.DATA_W(DATA_W)) u_core (
    .op (in_op),
    .a  (in_a),
    .b  (in_b),
    .y  (core_y)
  );

  assign shamt     = in_b[SH_W-1:0];
  assign in_ready  = !reset && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign k         = (rem > STEP_C) ? STEP_C : rem;
  assign step_last = (rem <= STEP_C);
  assign stall     = step_last && out_valid && !out_ready;
  assign out_zero  = (out_result == '0);

  always_comb begin
    acc_sh = acc >> k;
    case (op_q)
      OP_SLL:  acc_sh = acc << k;
      OP_SRA:  acc_sh = DATA_W'($signed(acc) >>> k);
      default: acc_sh = acc >> k;
    endcase
  end

  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    op_n    = op_q;
    res_n   = out_result;
    vld_n   = out_valid && !out_ready;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_shift_op(in_op) && (shamt != '0)) begin
            acc_n   = in_a;
            rem_n   = CNT_W'(shamt);
            op_n    = in_op;
            state_n = ST_SHIFT;
          end else begin
            res_n = is_shift_op(in_op) ? in_a : core_y;
            vld_n = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // A completing step waits while an undrained result still occupies the output.
        if (!stall) begin
          acc_n = acc_sh;
          rem_n = rem - k;
          if (step_last) begin
            res_n   = acc_sh;
            vld_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      acc        <= '0;
      rem        <= '0;
      op_q       <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      rem        <= rem_n;
      op_q       <= op_n;
      out_result <= res_n;
      out_valid  <= vld_n;
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Scoreboard bench for alu_iter_exec: stimulus queues expected results, a
// negedge monitor pops and compares on every output handshake.
module tb_alu_iter_exec;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int STEP = 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_op = 4'b0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic         out_zero;

  logic         d4_in_valid = 1'b0;
  logic         d4_in_ready;
  logic [3:0]   d4_in_op = 4'b0;
  logic [W-1:0] d4_in_a = '0, d4_in_b = '0;
  logic         d4_out_valid;
  logic         d4_out_ready = 1'b1;
  logic [W-1:0] d4_out_result;
  logic         d4_out_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  int pop_q[$];

  alu_iter_exec #(.DATA_W(W), .SHIFT_STEP(STEP)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero)
  );

  alu_iter_exec #(.DATA_W(W), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .in_op(d4_in_op), .in_a(d4_in_a), .in_b(d4_in_b), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .out_result(d4_out_result), .out_zero(d4_out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 1 + (s + STEP - 1) / STEP;
  endfunction

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h required=none", out_result);
        end else begin
          e = exp_q.pop_front();
          chk("result", out_result, e);
          chk("zero_flag", {31'b0, out_zero}, {31'b0, (e == '0)});
          pop_q.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] e, input bit push, output int acc_cyc);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    while (!in_ready && n < 200) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
      in_valid = 1'b0;
      acc_cyc = cyc;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int acc_cyc, output int lat, output int busy);
    lat = -1;
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = cyc - acc_cyc + 1; break; end
      if (!in_ready) busy++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] e, input int explat);
    int ac, lat, busy;
    send(op, a, b, e, 1'b1, ac);
    wait_valid(ac, lat, busy);
    chk({name, "_latency"}, lat, explat);
    chk({name, "_busy"}, busy, explat - 1);
  endtask

  task automatic run4(input string name, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] e, input int explat);
    int n = 0;
    int ac, lat;
    lat = -1;
    d4_in_valid = 1'b1; d4_in_op = op; d4_in_a = a; d4_in_b = b;
    @(negedge clk);
    while (!d4_in_ready && n < 50) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    ac = cyc;
    d4_in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (d4_out_valid) begin lat = cyc - ac + 1; break; end
    end
    chk({name, "_result"}, d4_out_result, e);
    chk({name, "_latency"}, lat, explat);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ac;
    bit seen;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_zero", {31'b0, out_zero}, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset two cycles in the middle of an SLL by 20; nothing may surface.
    send(OP_SLL, 32'h1, 32'd20, '0, 1'b0, ac);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'b0, in_ready}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", {31'b0, out_valid}, 0);
    chk("post_rst_out_result", out_result, 0);
    chk("post_rst_in_ready", {31'b0, in_ready}, 1);
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    chk("no_stale_result", {31'b0, seen}, 0);
    @(posedge clk); #1;

    do_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    do_op("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    do_op("slt_neg", OP_SLT, 32'h8000_0000, 32'h1, 32'h1, 1);
    do_op("slt_pos", OP_SLT, 32'h1, 32'h8000_0000, 32'h0, 1);
    do_op("beq_eq", OP_BEQ, 32'h1234, 32'h1234, 32'h1, 1);
    do_op("beq_ne", OP_BEQ, 32'h1234, 32'h1235, 32'h0, 1);
    do_op("op_f", 4'b1111, 32'h1234, 32'h5678, 32'h0, 1);
    do_op("op_4", 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1);
    do_op("and", OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1);
    do_op("or", OP_OR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1);
    do_op("xor", OP_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1);

    do_op("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, lat_of(31));
    do_op("sra4", OP_SRA, 32'h7FFF_FFFF, 32'd4, 32'h07FF_FFFF, lat_of(4));
    do_op("sra0", OP_SRA, 32'h8000_0000, 32'd0, 32'h8000_0000, 1);
    do_op("srl4", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, lat_of(4));
    do_op("srl_mask", OP_SRL, 32'hFFFF_FFFF, 32'h25, 32'h07FF_FFFF, lat_of(5));
    do_op("sll0", OP_SLL, 32'h1, 32'd0, 32'h1, 1);
    do_op("sll31", OP_SLL, 32'h3, 32'd31, 32'h8000_0000, lat_of(31));
    do_op("sll_mask0", OP_SLL, 32'hABCD, 32'h20, 32'hABCD, 1);

    // Back-pressure: ADD result held five cycles, then drained as XOR is accepted.
    begin
      int lat, busy;
      out_ready = 1'b0;
      send(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b1, ac);
      wait_valid(ac, lat, busy);
      chk("bp_add_latency", lat, 1);
      repeat (5) begin
        @(negedge clk);
        chk("bp_hold_result", out_result, 32'd5);
        chk("bp_hold_valid", {31'b0, out_valid}, 1);
        chk("bp_in_ready", {31'b0, in_ready}, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      do_op("bp_xor", OP_XOR, 32'hAAAA, 32'h5555, 32'hFFFF, 1);
    end

    // Streaming: eight ADDs accepted and returned on consecutive cycles.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    pop_q.delete();
    for (int i = 0; i < 8; i++) send(OP_ADD, W'(i), 32'h10, W'(i + 16), 1'b1, ac);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("stream_count", pop_q.size(), 8);
    for (int i = 1; i < pop_q.size(); i++) chk("stream_gap", pop_q[i] - pop_q[i-1], 1);

    run4("step4_sra31", OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 9);
    run4("step4_srl6", OP_SRL, 32'hF000_0000, 32'd6, 32'h03C0_0000, 3);
    run4("step4_sll0", OP_SLL, 32'h5A5A, 32'd0, 32'h5A5A, 1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
